// File: rtl/hall_decoder_if.sv
// Hall decoder bus: raw sensor input and error clear toward the decoder,
// decoded step, direction, period and status back to the consumer.
interface hall_decoder_if #(
    parameter int unsigned PERIOD_W = 16
);
    logic [2:0]          hall_in;
    logic                err_clr;
    logic [2:0]          step;
    logic                step_valid;
    logic                step_pulse;
    logic                direction;
    logic [PERIOD_W-1:0] step_period;
    logic                period_valid;
    logic                hall_error;
    logic                stalled;

    modport master (
        output hall_in, err_clr,
        input  step, step_valid, step_pulse, direction, step_period,
               period_valid, hall_error, stalled
    );

    modport slave (
        input  hall_in, err_clr,
        output step, step_valid, step_pulse, direction, step_period,
               period_valid, hall_error, stalled
    );
endinterface

// File: rtl/hall_decoder.sv
// Hall sensor decoder: synchronizes and glitch-filters three Hall inputs,
// maps them to a 6-step commutation index, and tracks direction, step
// period, invalid codes, skipped steps and stalls.
// Optional macro HALL_SKIP_TOLERANT_EN: accept single skipped steps
// (delta 2 forward, delta 4 reverse) with a halved period estimate.
module hall_decoder #(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned PERIOD_W   = 16,
    parameter int unsigned TIMEOUT    = 32'h0000_FFFF
) (
    input  logic          clk,
    input  logic          rst_n,
    hall_decoder_if.slave hall_bus
);

    localparam int unsigned FCNT_W = 8;
    localparam logic [PERIOD_W-1:0] CNT_MAX   = {PERIOD_W{1'b1}};
    localparam logic [PERIOD_W-1:0] TIMEOUT_V = PERIOD_W'(TIMEOUT);
    localparam logic [FCNT_W-1:0]   FILT_LAST = FCNT_W'(FILTER_LEN - 1);

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    logic [2:0]          r_sync1;
    logic [2:0]          r_sync2;
    logic [2:0]          r_filt_code;
    logic [FCNT_W-1:0]   r_filt_cnt;
    logic                r_acc_valid;

    state_t              r_state;
    logic [2:0]          r_step;
    logic                r_step_valid;
    logic                r_step_pulse;
    logic                r_direction;
    logic [PERIOD_W-1:0] r_step_period;
    logic                r_period_valid;
    logic                r_hall_error;
    logic                r_stalled;
    logic [PERIOD_W-1:0] r_period_cnt;

    logic                w_code_ok;
    logic [2:0]          w_new_step;
    logic [3:0]          w_diff;
    logic [2:0]          w_delta;
    logic                w_skip;
    logic                w_adjacent;
    logic                w_reverse;
    logic [PERIOD_W-1:0] w_cnt_inc;
    logic [PERIOD_W-1:0] w_dist;

    // Two-flop synchronizer for the asynchronous Hall inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
        end else begin
            r_sync1 <= hall_bus.hall_in;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new code only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt_code <= 3'b000;
            r_filt_cnt  <= '0;
            r_acc_valid <= 1'b0;
        end else begin
            r_acc_valid <= 1'b0;
            if (r_sync2 == r_filt_code) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FILT_LAST) begin
                r_filt_code <= r_sync2;
                r_filt_cnt  <= '0;
                r_acc_valid <= 1'b1;
            end else begin
                r_filt_cnt <= r_filt_cnt + FCNT_W'(1);
            end
        end
    end

    // Hall code to commutation step; 000 and 111 are invalid
    always_comb begin
        w_code_ok  = 1'b1;
        w_new_step = 3'd0;
        case (r_filt_code)
            3'b101:  w_new_step = 3'd0;
            3'b100:  w_new_step = 3'd1;
            3'b110:  w_new_step = 3'd2;
            3'b010:  w_new_step = 3'd3;
            3'b011:  w_new_step = 3'd4;
            3'b001:  w_new_step = 3'd5;
            default: w_code_ok  = 1'b0;
        endcase
    end

    // Step distance modulo 6 from the current step to the accepted one
    assign w_diff  = 4'(w_new_step) + 4'd6 - 4'(r_step);
    assign w_delta = (w_diff >= 4'd6) ? 3'(w_diff - 4'd6) : 3'(w_diff);

`ifdef HALL_SKIP_TOLERANT_EN
    assign w_skip = (w_delta == 3'd2) || (w_delta == 3'd4);
`else
    assign w_skip = 1'b0;
`endif

    assign w_adjacent = (w_delta == 3'd1) || (w_delta == 3'd5) || w_skip;
    assign w_reverse  = (w_delta == 3'd5) || (w_delta == 3'd4);

    // Saturating period counter increment and captured edge distance
    assign w_cnt_inc = (r_period_cnt == CNT_MAX) ? CNT_MAX : r_period_cnt + PERIOD_W'(1);
    assign w_dist    = w_cnt_inc;

    // Decoder state machine with registered outputs and period counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_ACQUIRE;
            r_step         <= 3'd0;
            r_step_valid   <= 1'b0;
            r_step_pulse   <= 1'b0;
            r_direction    <= 1'b0;
            r_step_period  <= '0;
            r_period_valid <= 1'b0;
            r_hall_error   <= 1'b0;
            r_stalled      <= 1'b0;
            r_period_cnt   <= '0;
        end else begin
            r_step_pulse <= 1'b0;
            r_period_cnt <= w_cnt_inc;
            if (hall_bus.err_clr) begin
                r_hall_error <= 1'b0;
            end

            if (r_acc_valid) begin
                if (!w_code_ok) begin
                    r_hall_error   <= 1'b1;
                    r_step_valid   <= 1'b0;
                    r_period_valid <= 1'b0;
                    r_state        <= ST_ACQUIRE;
                end else if (r_state == ST_ACQUIRE) begin
                    r_step       <= w_new_step;
                    r_step_valid <= 1'b1;
                    r_step_pulse <= 1'b1;
                    r_period_cnt <= '0;
                    r_state      <= ST_LOCKED;
                end else if (w_adjacent) begin
                    r_step        <= w_new_step;
                    r_step_pulse  <= 1'b1;
                    r_period_cnt  <= '0;
                    r_direction   <= w_reverse;
                    r_stalled     <= 1'b0;
                    r_step_period <= w_skip ? (w_dist >> 1) : w_dist;
                    if (r_state == ST_RUN) begin
                        r_period_valid <= 1'b1;
                    end
                    r_state <= ST_RUN;
                end else begin
                    // Skipped step: resync to the new position, distrust the period
                    r_hall_error   <= 1'b1;
                    r_step         <= w_new_step;
                    r_step_pulse   <= 1'b1;
                    r_period_cnt   <= '0;
                    r_period_valid <= 1'b0;
                    r_state        <= ST_LOCKED;
                end
            end else if (r_step_valid && (r_period_cnt == TIMEOUT_V)) begin
                r_stalled      <= 1'b1;
                r_period_valid <= 1'b0;
                r_state        <= ST_LOCKED;
            end
        end
    end

    assign hall_bus.step         = r_step;
    assign hall_bus.step_valid   = r_step_valid;
    assign hall_bus.step_pulse   = r_step_pulse;
    assign hall_bus.direction    = r_direction;
    assign hall_bus.step_period  = r_step_period;
    assign hall_bus.period_valid = r_period_valid;
    assign hall_bus.hall_error   = r_hall_error;
    assign hall_bus.stalled      = r_stalled;

endmodule
